// File: rtl/logic_gate_unit.sv
// ---------------------------------------------------------------------------
// logic_gate_unit
//
// Registered, parametrised multi-operand bitwise gate. Each accepted
// transaction folds NUM_IN operands of WIDTH bits with the selected
// operation (AND, OR, XOR, NAND). The result goes into a two-entry output
// FIFO so that results are never lost while the consumer stalls.
//
// Parameters:
//   WIDTH        operand/result width (>= 1)
//   NUM_IN       number of operands   (>= 2)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     producer presents a transaction
//   in_ready     block can accept a transaction this cycle
//   in_data      operand k at bits [k*WIDTH +: WIDTH]
//   in_op        0 AND, 1 OR, 2 XOR (odd parity), 3 NAND (inverted AND fold)
//   out_valid    out_data/out_all_ones hold a result
//   out_ready    consumer takes the result this cycle
//   out_data     oldest buffered result
//   out_all_ones reduction AND of out_data
//   op_count     16-bit accepted-transaction counter (optional)
//
// Optional feature:
//   LOGIC_GATE_UNIT_STATS_EN  when defined, adds the op_count port and its
//                             counter. When undefined both are absent.
// ---------------------------------------------------------------------------
module logic_gate_unit #(
    parameter int WIDTH  = 1,
    parameter int NUM_IN = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [1:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_all_ones
`ifdef LOGIC_GATE_UNIT_STATS_EN
    ,
    output logic [15:0]             op_count
`endif
);

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } gate_op_t;

    logic [WIDTH-1:0] fold_and;
    logic [WIDTH-1:0] fold_or;
    logic [WIDTH-1:0] fold_xor;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] mem_data [0:1];
    logic             mem_ones [0:1];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    logic             push;
    logic             pop;

    // Ready and valid come straight from the registered count, so neither
    // handshake side ever sees a combinational path from the other.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_data     = mem_data[rd_ptr];
    assign out_all_ones = mem_ones[rd_ptr];

    // Fold every operand lane-wise. NAND is the inversion of the full AND
    // fold rather than a chain of two-input NANDs.
    always_comb begin
        fold_and = in_data[WIDTH-1:0];
        fold_or  = in_data[WIDTH-1:0];
        fold_xor = in_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            fold_and = fold_and & in_data[k*WIDTH +: WIDTH];
            fold_or  = fold_or  | in_data[k*WIDTH +: WIDTH];
            fold_xor = fold_xor ^ in_data[k*WIDTH +: WIDTH];
        end
        case (gate_op_t'(in_op))
            OP_AND:  result = fold_and;
            OP_OR:   result = fold_or;
            OP_XOR:  result = fold_xor;
            OP_NAND: result = ~fold_and;
            default: result = fold_and;
        endcase
    end

    // Two-entry FIFO. Storage is cleared on reset so out_data reads zero
    // until the first result arrives. A simultaneous push and pop leaves the
    // count unchanged while both pointers advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_ones[0] <= 1'b0;
            mem_ones[1] <= 1'b0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= result;
                mem_ones[wr_ptr] <= &result;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef LOGIC_GATE_UNIT_STATS_EN
    // Counts accepted transactions only; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= 16'd0;
        end else if (push) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// ---------------------------------------------------------------------------
// tb_logic_gate_unit
//
// Self-checking bench for logic_gate_unit. One 8-bit, 3-operand instance is
// checked through a scoreboard queue (expected results pushed on accept,
// popped on each output handshake) driven by a vector table and a few
// hand-written sequences; a second default-parameter instance covers the
// plain 2-input, 1-bit gate.
// ---------------------------------------------------------------------------
module tb_logic_gate_unit;

    localparam int W = 8;
    localparam int N = 3;

    typedef struct packed {
        logic [W-1:0] data;
        logic         ones;
    } sb_entry_t;

    typedef struct packed {
        logic [N*W-1:0] operands;
        logic [1:0]     op;
        logic [W-1:0]   exp_data;
        logic           exp_ones;
    } vector_t;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic [1:0]     in_op;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_all_ones;

    logic           in_valid1;
    logic           in_ready1;
    logic [1:0]     in_data1;
    logic [1:0]     in_op1;
    logic           out_valid1;
    logic           out_ready1;
    logic [0:0]     out_data1;
    logic           out_all_ones1;

`ifdef LOGIC_GATE_UNIT_STATS_EN
    logic [15:0]    op_count;
    logic [15:0]    op_count1;
`endif

    int             checks;
    int             errors;
    sb_entry_t      sb[$];
    sb_entry_t      exp_pending;

    logic_gate_unit #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_all_ones (out_all_ones)
`ifdef LOGIC_GATE_UNIT_STATS_EN
        ,
        .op_count     (op_count)
`endif
    );

    logic_gate_unit dut1 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid1),
        .in_ready     (in_ready1),
        .in_data      (in_data1),
        .in_op        (in_op1),
        .out_valid    (out_valid1),
        .out_ready    (out_ready1),
        .out_data     (out_data1),
        .out_all_ones (out_all_ones1)
`ifdef LOGIC_GATE_UNIT_STATS_EN
        ,
        .op_count     (op_count1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Lane-wise reference: count set bits per lane across all operands.
    function automatic sb_entry_t model(input logic [N*W-1:0] d, input logic [1:0] op);
        sb_entry_t r;
        for (int b = 0; b < W; b++) begin
            int cnt;
            cnt = 0;
            for (int k = 0; k < N; k++) cnt += int'(d[k*W + b]);
            case (op)
                2'd0:    r.data[b] = (cnt == N);
                2'd1:    r.data[b] = (cnt > 0);
                2'd2:    r.data[b] = cnt[0];
                default: r.data[b] = (cnt != N);
            endcase
        end
        r.ones = &r.data;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one transaction and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [N*W-1:0] d, input logic [1:0] op,
                                 input sb_entry_t exp);
        int  waited;
        logic took;
        in_valid    = 1'b1;
        in_data     = d;
        in_op       = op;
        exp_pending = exp;
        waited      = 0;
        took        = 1'b0;
        while (!took && waited < 20) begin
            took = in_ready;
            tick();
            waited++;
        end
        if (!took) checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("drain_remaining", sb.size(), 32'd0);
    endtask

    // Scoreboard monitor. Inputs are stable at the falling edge, so it sees
    // exactly the handshakes the next rising edge will perform.
    always @(negedge clk) begin : monitor
        sb_entry_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_data", {24'd0, out_data}, {24'd0, e.data});
                    checkOutput("sb_all_ones", {31'd0, out_all_ones}, {31'd0, e.ones});
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_pending);
        end
    end

    vector_t vectors [0:8];

    initial begin
        sb_entry_t    e;
        logic [N*W-1:0] d;
        logic [1:0]   op;
        logic [1:0]   pat1 [0:3];
        logic         exp1 [0:3];

        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_op = 2'd0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; in_op1 = 2'd0; out_ready1 = 1'b1;
        exp_pending = '0;

        vectors[0] = '{24'hAACCF0, 2'd0, 8'h80, 1'b0};
        vectors[1] = '{24'hAACCF0, 2'd1, 8'hFE, 1'b0};
        vectors[2] = '{24'hAACCF0, 2'd2, 8'h96, 1'b0};
        vectors[3] = '{24'hAACCF0, 2'd3, 8'h7F, 1'b0};
        vectors[4] = '{24'hFFFFFF, 2'd0, 8'hFF, 1'b1};
        vectors[5] = '{24'h000000, 2'd1, 8'h00, 1'b0};
        vectors[6] = '{24'h000000, 2'd3, 8'hFF, 1'b1};
        vectors[7] = '{24'hFFFFFF, 2'd2, 8'hFF, 1'b1};
        vectors[8] = '{24'hFFFF00, 2'd2, 8'h00, 1'b0};

        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_data", {24'd0, out_data}, 32'd0);
        checkOutput("reset_all_ones", {31'd0, out_all_ones}, 32'd0);
`ifdef LOGIC_GATE_UNIT_STATS_EN
        checkOutput("reset_op_count", {16'd0, op_count}, 32'd0);
`endif

        // Default 1-bit, 2-input AND: each result one cycle after accept.
        pat1[0] = 2'b00; pat1[1] = 2'b01; pat1[2] = 2'b10; pat1[3] = 2'b11;
        exp1[0] = 1'b0;  exp1[1] = 1'b0;  exp1[2] = 1'b0;  exp1[3] = 1'b1;
        in_valid1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data1 = pat1[i];
            tick();
            checkOutput($sformatf("gate1_valid_%0d", i), {31'd0, out_valid1}, 32'd1);
            checkOutput($sformatf("gate1_data_%0d", i), {31'd0, out_data1}, {31'd0, exp1[i]});
        end
        in_valid1 = 1'b0;
        tick();
        checkOutput("gate1_idle_valid", {31'd0, out_valid1}, 32'd0);

        // Vector table, back to back with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            e.data = vectors[i].exp_data;
            e.ones = vectors[i].exp_ones;
            applyStimulus(vectors[i].operands, vectors[i].op, e);
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: two accepted, third stalls until the first pop.
        out_ready = 1'b0;
        applyStimulus(24'h0F0F0F, 2'd1, model(24'h0F0F0F, 2'd1));
        applyStimulus(24'h123456, 2'd2, model(24'h123456, 2'd2));
        in_data = 24'hFFFFFF; in_op = 2'd0; exp_pending = model(24'hFFFFFF, 2'd0);
        checkOutput("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("bp_still_full", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_stable_data", {24'd0, out_data}, {24'd0, model(24'h0F0F0F, 2'd1).data});
        out_ready = 1'b1;
        tick();
        checkOutput("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        drain();

        // Steady state with one entry pending: push and pop every cycle.
        out_ready = 1'b0;
        applyStimulus(24'h00FF00, 2'd3, model(24'h00FF00, 2'd3));
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d  = N*W'($urandom);
            op = 2'($urandom_range(0, 3));
            in_data = d; in_op = op; exp_pending = model(d, op);
            checkOutput($sformatf("stream_in_ready_%0d", i), {31'd0, in_ready}, 32'd1);
            checkOutput($sformatf("stream_out_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Reset while full with a coincident input that must be dropped.
        out_ready = 1'b0;
        applyStimulus(24'hFFFFFF, 2'd0, model(24'hFFFFFF, 2'd0));
        applyStimulus(24'hF0F0F0, 2'd1, model(24'hF0F0F0, 2'd1));
        rst = 1'b1;
        in_valid = 1'b1; in_data = 24'hFFFFFF; in_op = 2'd1;
        exp_pending = model(24'hFFFFFF, 2'd1);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_out_data", {24'd0, out_data}, 32'd0);
        checkOutput("midrst_all_ones", {31'd0, out_all_ones}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("midrst_no_output_%0d", i), {31'd0, out_valid}, 32'd0);
        end

`ifdef LOGIC_GATE_UNIT_STATS_EN
        // Stalled cycles and pops leave the counter alone.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("stats_reset", {16'd0, op_count}, 32'd0);
        out_ready = 1'b0;
        applyStimulus(24'h0000FF, 2'd1, model(24'h0000FF, 2'd1));
        applyStimulus(24'h0000FF, 2'd2, model(24'h0000FF, 2'd2));
        tick();
        tick();
        tick();
        checkOutput("stats_stalled", {16'd0, op_count}, 32'd2);
        in_valid = 1'b0;
        drain();
        tick();
        checkOutput("stats_after_pops", {16'd0, op_count}, 32'd2);

        // 65537 accepts from reset wrap the counter to 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 24'hAACCF0; in_op = 2'd2;
        exp_pending = model(24'hAACCF0, 2'd2);
        for (int i = 0; i < 65537; i++) tick();
        in_valid = 1'b0;
        checkOutput("stats_wrap", {16'd0, op_count}, 32'd1);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
